byte_mem_io_responder: RTL and testbench
========================================

// Module: byte_mem_io_responder
// PURPOSE
// Responder end of the byte-wide memory bus driven by the CPU memory controller.
// Serves 1-byte reads and writes to an on-chip RAM, and to a memory-mapped IO window
// (TX byte FIFO, RX byte FIFO, status, halt). Drives io_buffer_full back to the
// controller so it can stall before the TX FIFO overflows.
// PARAMETERS
// RAM_AW      17  RAM index width; RAM = 2**RAM_AW bytes at 0x00000-0x1FFFF
// TX_DEPTH    8   TX FIFO entries (power of two)
// RX_DEPTH    4   RX FIFO entries (power of two)
// FULL_MARGIN 2   io_buffer_full asserts when tx_count >= TX_DEPTH-FULL_MARGIN
// PORTS
// clk          in   1   clock
// rst          in   1   synchronous active-high reset
// rdy          in   1   global enable; low = no state change anywhere
// mem_rw       in   1   1 = write, 0 = read
// mem_addr     in   32  byte address
// mem_dout     in   8   write data from controller
// mem_din      out  8   read data to controller, registered
// io_buffer_full out 1  TX FIFO near full (see above), combinational from count
// tx_valid     out  1   TX FIFO non-empty
// tx_data      out  8   TX FIFO head byte
// tx_ready     in   1   sink accepts head when tx_valid && tx_ready
// rx_valid     in   1   source offers rx_data
// rx_data      in   8   incoming byte
// rx_ready     out  1   RX FIFO not full
// tx_overflow  out  1   sticky: TX write dropped because FIFO was full
// sim_halt     out  1   sticky: halt register written
// BEHAVIOUR
// - Reset: mem_din=0, FIFOs empty, tx_overflow=0, sim_halt=0, io_buffer_full=0,
//   tx_valid=0, rx_ready=1. RAM contents not reset.
// - Decode: mem_addr[17]=0 -> RAM[mem_addr[16:0]]; mem_addr[17]=1 -> IO window.
//   IO regs: 0x30000 DATA, 0x30004 STATUS/HALT; other IO addresses read 0, writes ignored.
// - Every rdy=1 cycle is one bus transaction; no request/valid strobe.
//   Read: mem_din <= selected byte at clock edge; byte for address presented in cycle N
//   is on mem_din in cycle N+1 (1-cycle latency).
//   Write: RAM updated at the edge; mem_din holds previous value.
// - DATA read: pop RX FIFO in the same edge; mem_din <= head byte, or 0x00 if RX empty
//   (no pointer change). DATA write: push mem_dout to TX FIFO; if TX full, drop and set
//   tx_overflow.
// - STATUS read: mem_din <= {6'b0, rx_nonempty, tx_full}.
//   HALT write (0x30004): sim_halt <= 1.
// - rdy=0: no RAM write, no FIFO push/pop from the bus side, mem_din holds. TX drain
//   (tx_ready) and RX fill (rx_valid) also frozen.
// - TX FIFO: push from bus and pop by sink in the same cycle -> count unchanged, both
//   take effect. Pop when empty is impossible (tx_valid=0). Pointers wrap modulo
//   TX_DEPTH.
// - RX FIFO: push when rx_valid && rx_ready. A bus pop and a source push in the same
//   cycle are both honoured; a push into an empty FIFO is not visible to a same-cycle
//   pop (that pop returns 0x00).
// - io_buffer_full = (tx_count >= TX_DEPTH-FULL_MARGIN); the controller must stop
//   issuing DATA writes while it is high. Margin covers 2 in-flight writes.
// - Reset mid-transaction: any pending read result is discarded (mem_din=0) and FIFO
//   contents are lost.
// TESTING
// - Write 0xA5 to 0x00010, then read 0x00010 -> mem_din=0xA5 exactly one cycle after
//   the read address is presented.
// - Push 6 writes to 0x30000 with tx_ready=0 -> io_buffer_full=1 once count=6.
//   8 writes -> tx_valid=1; 9th write -> tx_overflow=1, count stays 8.
// - tx_ready=1 with a simultaneous DATA write at count=3 -> count stays 3;
//   bytes emerge in write order.
// - rx_valid with 0x11, 0x22; read 0x30000 twice -> 0x11 then 0x22;
//   a third read -> 0x00 and STATUS bit1=0.
// - rdy=0 during a write to 0x00020 (old value 0x00) -> RAM unchanged, mem_din held,
//   FIFO counts held.
// - Write 0x30004 -> sim_halt=1 and stays 1; rst pulse mid-stream -> all outputs
//   return to reset values next cycle.

Source files
------------

// File: rtl/byte_mem_io_responder_if.sv
// Byte-wide memory bus between the CPU memory controller (master) and the
// RAM/IO responder (slave).
interface byte_mem_io_if;
  logic        rdy;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (
    output rdy, mem_rw, mem_addr, mem_dout,
    input  mem_din, io_buffer_full
  );

  modport slave (
    input  rdy, mem_rw, mem_addr, mem_dout,
    output mem_din, io_buffer_full
  );
endinterface

// File: rtl/byte_mem_io_responder.sv
// Responder for the byte-wide CPU memory bus: on-chip RAM plus an IO window
// holding a TX byte FIFO, an RX byte FIFO, a status register and a halt flag.
module byte_mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 8,
  parameter int RX_DEPTH    = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic         clk,
  input  logic         rst,
  byte_mem_io_if.slave bus,
  output logic         tx_valid_o,
  output logic [7:0]   tx_data_o,
  input  logic         tx_ready_i,
  input  logic         rx_valid_i,
  input  logic [7:0]   rx_data_i,
  output logic         rx_ready_o,
  output logic         tx_overflow_o,
  output logic         sim_halt_o
);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [31:0]   DATA_ADDR   = 32'h0003_0000;
  localparam logic [31:0]   STAT_ADDR   = 32'h0003_0004;
  localparam logic [TX_AW:0] TX_FULL_CNT = (TX_AW + 1)'(TX_DEPTH);
  localparam logic [TX_AW:0] TX_NEAR_CNT = (TX_AW + 1)'(TX_DEPTH - FULL_MARGIN);
  localparam logic [RX_AW:0] RX_FULL_CNT = (RX_AW + 1)'(RX_DEPTH);

  logic [7:0]       ram_q    [2**RAM_AW];
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [TX_AW-1:0] tx_rd_ptr_q, tx_wr_ptr_q;
  logic [TX_AW:0]   tx_count_q;
  logic [RX_AW-1:0] rx_rd_ptr_q, rx_wr_ptr_q;
  logic [RX_AW:0]   rx_count_q;
  logic [7:0]       mem_din_q, mem_din_d;
  logic             tx_overflow_q, sim_halt_q;

  logic is_ram, is_data, is_stat, bus_wr, bus_rd;
  logic tx_full, tx_push, tx_drop, tx_pop;
  logic rx_full, rx_nonempty, rx_push, rx_pop, ram_we;

  assign is_ram  = !bus.mem_addr[RAM_AW];
  assign is_data = (bus.mem_addr == DATA_ADDR);
  assign is_stat = (bus.mem_addr == STAT_ADDR);
  assign bus_wr  = bus.rdy &&  bus.mem_rw;
  assign bus_rd  = bus.rdy && !bus.mem_rw;

  assign tx_full     = (tx_count_q == TX_FULL_CNT);
  assign rx_full     = (rx_count_q == RX_FULL_CNT);
  assign rx_nonempty = (rx_count_q != '0);

  // A full TX FIFO drops the write even if the sink drains a byte on the same edge.
  assign tx_push = bus_wr && is_data && !tx_full;
  assign tx_drop = bus_wr && is_data &&  tx_full;
  assign tx_pop  = bus.rdy && tx_valid_o && tx_ready_i;
  assign rx_push = bus.rdy && rx_valid_i && rx_ready_o;
  assign rx_pop  = bus_rd && is_data && rx_nonempty;
  assign ram_we  = bus_wr && is_ram && !rst;

  assign tx_valid_o         = (tx_count_q != '0);
  assign tx_data_o          = tx_mem_q[tx_rd_ptr_q];
  assign rx_ready_o         = !rx_full;
  assign tx_overflow_o      = tx_overflow_q;
  assign sim_halt_o         = sim_halt_q;
  assign bus.mem_din        = mem_din_q;
  assign bus.io_buffer_full = (tx_count_q >= TX_NEAR_CNT);

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    mem_din_d = mem_din_q;
    if (bus_rd) begin
      if (is_ram)       mem_din_d = ram_q[bus.mem_addr[RAM_AW-1:0]];
      else if (is_data) mem_din_d = rx_nonempty ? rx_mem_q[rx_rd_ptr_q] : 8'h00;
      else if (is_stat) mem_din_d = {6'b0, rx_nonempty, tx_full};
      else              mem_din_d = 8'h00;
    end
  end

  // NOTE: storage arrays are not reset; pointers and counts alone define FIFO contents.
  always_ff @(posedge clk) begin
    if (ram_we)  ram_q[bus.mem_addr[RAM_AW-1:0]] <= bus.mem_dout;
    if (tx_push) tx_mem_q[tx_wr_ptr_q]           <= bus.mem_dout;
    if (rx_push) rx_mem_q[rx_wr_ptr_q]           <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_din_q     <= 8'h00;
      tx_rd_ptr_q   <= '0;
      tx_wr_ptr_q   <= '0;
      tx_count_q    <= '0;
      rx_rd_ptr_q   <= '0;
      rx_wr_ptr_q   <= '0;
      rx_count_q    <= '0;
      tx_overflow_q <= 1'b0;
      sim_halt_q    <= 1'b0;
    end else if (bus.rdy) begin
      mem_din_q <= mem_din_d;
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TX_AW'(1);
      tx_count_q <= tx_count_q + (TX_AW + 1)'(tx_push) - (TX_AW + 1)'(tx_pop);
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RX_AW'(1);
      rx_count_q <= rx_count_q + (RX_AW + 1)'(rx_push) - (RX_AW + 1)'(rx_pop);
      if (tx_drop)           tx_overflow_q <= 1'b1;
      if (bus_wr && is_stat) sim_halt_q    <= 1'b1;
    end
  end
endmodule

// File: tb/tb_byte_mem_io_responder.sv
// Directed plus randomized bench for byte_mem_io_responder, checked against a
// queue-based model of the RAM, FIFOs and sticky flags.
module tb_byte_mem_io_responder;
  localparam int TX_DEPTH    = 8;
  localparam int RX_DEPTH    = 4;
  localparam int FULL_MARGIN = 2;
  localparam logic [31:0] DATA_A = 32'h0003_0000;
  localparam logic [31:0] STAT_A = 32'h0003_0004;
  localparam logic [31:0] NONE_A = 32'h0003_000C;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid, tx_ready, rx_valid, rx_ready, tx_overflow, sim_halt;
  logic [7:0] tx_data, rx_data;

  byte_mem_io_if bus ();

  byte_mem_io_responder #(
    .RAM_AW(17), .TX_DEPTH(TX_DEPTH), .RX_DEPTH(RX_DEPTH), .FULL_MARGIN(FULL_MARGIN)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .rx_valid_i(rx_valid), .rx_data_i(rx_data), .rx_ready_o(rx_ready),
    .tx_overflow_o(tx_overflow), .sim_halt_o(sim_halt)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [7:0] ram_m[int];
  logic [7:0] exp_din;
  bit         din_known;
  bit         exp_ovf, exp_halt;
  int         total = 0;
  int         bad   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    bit tx_full_pre, rx_had, tx_pop_now, rx_push_now;
    int idx;
    if (rst) begin
      txq.delete(); rxq.delete();
      exp_din = 8'h00; din_known = 1'b1; exp_ovf = 1'b0; exp_halt = 1'b0;
      return;
    end
    if (!bus.rdy) return;
    tx_full_pre = (txq.size() == TX_DEPTH);
    rx_had      = (rxq.size() != 0);
    tx_pop_now  = (txq.size() != 0) && tx_ready;
    rx_push_now = rx_valid && (rxq.size() < RX_DEPTH);
    idx         = int'(bus.mem_addr[16:0]);
    if (bus.mem_rw) begin
      if (!bus.mem_addr[17]) ram_m[idx] = bus.mem_dout;
      else if (bus.mem_addr == DATA_A) begin
        if (tx_full_pre) exp_ovf = 1'b1;
        else txq.push_back(bus.mem_dout);
      end else if (bus.mem_addr == STAT_A) exp_halt = 1'b1;
    end else begin
      din_known = 1'b1;
      if (!bus.mem_addr[17]) begin
        if (ram_m.exists(idx)) exp_din = ram_m[idx];
        else din_known = 1'b0;
      end else if (bus.mem_addr == DATA_A) exp_din = rx_had ? rxq.pop_front() : 8'h00;
      else if (bus.mem_addr == STAT_A)     exp_din = {6'b0, rx_had, tx_full_pre};
      else                                 exp_din = 8'h00;
    end
    if (tx_pop_now)  void'(txq.pop_front());
    if (rx_push_now) rxq.push_back(rx_data);
  endtask

  task automatic check_all();
    if (din_known) check("mem_din", bus.mem_din, exp_din);
    check("io_buffer_full", bus.io_buffer_full, txq.size() >= TX_DEPTH - FULL_MARGIN);
    check("tx_valid", tx_valid, txq.size() != 0);
    if (txq.size() != 0) check("tx_data", tx_data, txq[0]);
    check("rx_ready", rx_ready, rxq.size() < RX_DEPTH);
    check("tx_overflow", tx_overflow, exp_ovf);
    check("sim_halt", sim_halt, exp_halt);
  endtask

  task automatic drive(bit r, bit rw, logic [31:0] a, logic [7:0] d);
    bus.rdy = r; bus.mem_rw = rw; bus.mem_addr = a; bus.mem_dout = d;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bus_op(bit rw, logic [31:0] a, logic [7:0] d);
    drive(1'b1, rw, a, d);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    #1;
    cycle(); cycle();
    check("rst_din", bus.mem_din, 8'h00);
    check("rst_rx_ready", rx_ready, 1'b1);
    rst = 1'b0;

    // RAM write then read, one-cycle read latency
    bus_op(1'b1, 32'h10, 8'hA5);
    check("wr_holds_din", bus.mem_din, 8'h00);
    bus_op(1'b0, 32'h10, 8'h00);
    check("ram_rd_latency", bus.mem_din, 8'hA5);

    // rdy=0 freezes RAM, mem_din and both FIFOs
    bus_op(1'b1, 32'h20, 8'h00);
    bus_op(1'b1, DATA_A, 8'hC1);
    bus_op(1'b1, DATA_A, 8'hC2);
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    drive(1'b0, 1'b1, 32'h20, 8'h77);
    cycle();
    check("rdy0_din_held", bus.mem_din, 8'hA5);
    check("rdy0_tx_head", tx_data, 8'hC1);
    tx_ready = 1'b0; rx_valid = 1'b0;
    bus_op(1'b0, 32'h20, 8'h00);
    check("rdy0_ram_unchanged", bus.mem_din, 8'h00);
    bus_op(1'b0, STAT_A, 8'h00);
    check("rdy0_rx_empty", bus.mem_din, 8'h00);
    tx_ready = 1'b1;
    bus_op(1'b0, NONE_A, 8'h00);
    bus_op(1'b0, NONE_A, 8'h00);
    check("drain2_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // TX fill to near-full, full and overflow
    for (int i = 0; i < 9; i++) begin
      bus_op(1'b1, DATA_A, 8'(8'h40 + i));
      if (i == 4) check("ibf_at5", bus.io_buffer_full, 1'b0);
      if (i == 5) check("ibf_at6", bus.io_buffer_full, 1'b1);
      if (i == 7) check("ovf_at8", tx_overflow, 1'b0);
    end
    check("ovf_at9", tx_overflow, 1'b1);
    bus_op(1'b0, STAT_A, 8'h00);
    check("status_tx_full", bus.mem_din, 8'h01);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_order", tx_data, 8'(8'h40 + i));
      bus_op(1'b0, NONE_A, 8'h00);
    end
    check("tx_drained", tx_valid, 1'b0);

    // Simultaneous push and pop at count 3
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_op(1'b1, DATA_A, 8'(8'h60 + i));
    tx_ready = 1'b1;
    bus_op(1'b1, DATA_A, 8'h63);
    check("pushpop_head", tx_data, 8'h61);
    bus_op(1'b0, NONE_A, 8'h00);
    bus_op(1'b0, NONE_A, 8'h00);
    check("cnt3_one_left", tx_valid, 1'b1);
    check("cnt3_last", tx_data, 8'h63);
    bus_op(1'b0, NONE_A, 8'h00);
    check("cnt3_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // RX fill then bus reads, including read from empty
    rx_valid = 1'b1; rx_data = 8'h11;
    bus_op(1'b0, NONE_A, 8'h00);
    rx_data = 8'h22;
    bus_op(1'b0, NONE_A, 8'h00);
    rx_valid = 1'b0;
    bus_op(1'b0, DATA_A, 8'h00);
    check("rx_first", bus.mem_din, 8'h11);
    bus_op(1'b0, DATA_A, 8'h00);
    check("rx_second", bus.mem_din, 8'h22);
    bus_op(1'b0, DATA_A, 8'h00);
    check("rx_empty_read", bus.mem_din, 8'h00);
    bus_op(1'b0, STAT_A, 8'h00);
    check("rx_status_bit1", bus.mem_din[1], 1'b0);

    // Halt flag is sticky
    bus_op(1'b1, STAT_A, 8'h00);
    check("halt_set", sim_halt, 1'b1);
    bus_op(1'b0, STAT_A, 8'h00);
    bus_op(1'b1, 32'h30, 8'h5A);
    check("halt_sticky", sim_halt, 1'b1);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 3)      a = 32'h100 + 32'($urandom_range(0, 7)) + ($urandom_range(0, 1) != 0 ? 32'h0004_0000 : 32'h0);
      else if (sel < 7) a = DATA_A;
      else if (sel < 9) a = STAT_A;
      else              a = ($urandom_range(0, 1) != 0) ? NONE_A : 32'h0002_0000;
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = ($urandom_range(0, 1) != 0);
      rx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0, a, 8'($urandom));
      cycle();
      rst = 1'b0;
    end

    // Reset mid-stream discards the pending read and FIFO contents
    tx_ready = 1'b0; rx_valid = 1'b1; rx_data = 8'h3C;
    bus_op(1'b1, DATA_A, 8'h01);
    bus_op(1'b1, DATA_A, 8'h02);
    bus_op(1'b1, STAT_A, 8'h00);
    rx_valid = 1'b0;
    rst = 1'b1;
    bus_op(1'b0, 32'h10, 8'h00);
    check("rst_mid_din", bus.mem_din, 8'h00);
    check("rst_mid_tx_valid", tx_valid, 1'b0);
    check("rst_mid_ovf", tx_overflow, 1'b0);
    check("rst_mid_halt", sim_halt, 1'b0);
    check("rst_mid_ibf", bus.io_buffer_full, 1'b0);
    rst = 1'b0;
    bus_op(1'b0, DATA_A, 8'h00);
    check("rst_mid_rx_lost", bus.mem_din, 8'h00);
    bus_op(1'b0, 32'h10, 8'h00);
    check("ram_survives_rst", bus.mem_din, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
